// File: rtl/csc_pkg.sv
// Shared types and Q8 coefficient tables for the RGB->YCbCr converter.
package csc_pkg;

  localparam int unsigned FRAC_W_DEF = 8;
  localparam int unsigned COEF_W     = 10;

  typedef enum logic {
    BT601 = 1'b0,
    BT709 = 1'b1
  } csc_std_e;

  typedef struct packed {
    logic signed [COEF_W-1:0] y_r;
    logic signed [COEF_W-1:0] y_g;
    logic signed [COEF_W-1:0] y_b;
    logic signed [COEF_W-1:0] cb_r;
    logic signed [COEF_W-1:0] cb_g;
    logic signed [COEF_W-1:0] cb_b;
    logic signed [COEF_W-1:0] cr_r;
    logic signed [COEF_W-1:0] cr_g;
    logic signed [COEF_W-1:0] cr_b;
  } coef_set_t;

  localparam coef_set_t COEF_BT601 = '{
    y_r:  10'sd76,   y_g:  10'sd150,  y_b:  10'sd29,
    cb_r: -10'sd43,  cb_g: -10'sd84,  cb_b: 10'sd128,
    cr_r: 10'sd128,  cr_g: -10'sd107, cr_b: -10'sd20
  };

  localparam coef_set_t COEF_BT709 = '{
    y_r:  10'sd54,   y_g:  10'sd183,  y_b:  10'sd18,
    cb_r: -10'sd29,  cb_g: -10'sd99,  cb_b: 10'sd128,
    cr_r: 10'sd128,  cr_g: -10'sd116, cr_b: -10'sd12
  };

endpackage

// File: rtl/csc_mac3.sv
// One output channel: three products, optional mid-scale offset, round, clamp.
// Three registered stages: products, offset+rounded sum, shifted/clamped result.
module csc_mac3
  import csc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAC_W    = FRAC_W_DEF,
  parameter bit          OFFSET_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        px_a,
  input  logic [DATA_W-1:0]        px_b,
  input  logic [DATA_W-1:0]        px_c,
  input  logic signed [COEF_W-1:0] coef_a,
  input  logic signed [COEF_W-1:0] coef_b,
  input  logic signed [COEF_W-1:0] coef_c,
  input  logic                     out_en,
  output logic [DATA_W-1:0]        result
);

  localparam int unsigned ACC_W = DATA_W + FRAC_W + 2;
  localparam logic signed [ACC_W-1:0] OFFSET_C =
    OFFSET_EN ? ACC_W'(1 << (DATA_W - 1 + FRAC_W)) : '0;
  localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_C   = ACC_W'((1 << DATA_W) - 1);

  logic signed [ACC_W-1:0] prod_a_d, prod_a_q;
  logic signed [ACC_W-1:0] prod_b_d, prod_b_q;
  logic signed [ACC_W-1:0] prod_c_d, prod_c_q;
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic signed [ACC_W-1:0] shifted_c;
  logic [DATA_W-1:0]       clamp_c;
  logic [DATA_W-1:0]       res_d, res_q;

  always_comb begin
    prod_a_d  = ACC_W'($signed({1'b0, px_a})) * ACC_W'(coef_a);
    prod_b_d  = ACC_W'($signed({1'b0, px_b})) * ACC_W'(coef_b);
    prod_c_d  = ACC_W'($signed({1'b0, px_c})) * ACC_W'(coef_c);
    sum_d     = prod_a_q + prod_b_q + prod_c_q + OFFSET_C + ROUND_C;
    shifted_c = sum_q >>> FRAC_W;
    clamp_c   = DATA_W'(shifted_c);
    if (shifted_c < 0) begin
      clamp_c = '0;
    end else if (shifted_c > MAX_C) begin
      clamp_c = '1;
    end
    // Blanked samples leave the pipe as zero
    res_d = out_en ? clamp_c : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
      prod_c_q <= '0;
      sum_q    <= '0;
      res_q    <= '0;
    end else begin
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      prod_c_q <= prod_c_d;
      sum_q    <= sum_d;
      res_q    <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/ycbcr_csc_pipe.sv
// 3-cycle RGB->YCbCr pipeline with per-frame standard select.
// Define CSC_BT709_EN to build in the BT.709 table and vsync-latched std_sel.
module ycbcr_csc_pipe
  import csc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_img_vsync,
  input  logic              per_img_href,
  input  logic [DATA_W-1:0] per_img_red,
  input  logic [DATA_W-1:0] per_img_green,
  input  logic [DATA_W-1:0] per_img_blue,
  input  logic              std_sel,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr,
  output logic              active_std
);

  logic [2:0] vsync_sr_d, vsync_sr_q;
  logic [2:0] href_sr_d, href_sr_q;
  csc_std_e   active_std_d, active_std_q;
  coef_set_t  coef_c;

`ifdef CSC_BT709_EN
  logic vsync_prev_d, vsync_prev_q;
  logic armed_d, armed_q;
  logic vsync_rise_c;

  // armed_q masks the first cycle after reset so a vsync already high is not an edge
  always_comb begin
    vsync_prev_d = per_img_vsync;
    armed_d      = 1'b1;
    vsync_rise_c = armed_q & ~vsync_prev_q & per_img_vsync;
    active_std_d = vsync_rise_c ? csc_std_e'(std_sel) : active_std_q;
    coef_c       = (active_std_q == BT709) ? COEF_BT709 : COEF_BT601;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      armed_q      <= armed_d;
    end
  end
`else
  logic unused_std_sel;

  assign unused_std_sel = std_sel;

  always_comb begin
    active_std_d = BT601;
    coef_c       = COEF_BT601;
  end
`endif

  always_comb begin
    vsync_sr_d = {vsync_sr_q[1:0], per_img_vsync};
    href_sr_d  = {href_sr_q[1:0], per_img_href};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_sr_q   <= '0;
      href_sr_q    <= '0;
      active_std_q <= BT601;
    end else begin
      vsync_sr_q   <= vsync_sr_d;
      href_sr_q    <= href_sr_d;
      active_std_q <= active_std_d;
    end
  end

  // href_sr_q[1] is the valid flag of the sample entering the final stage
  csc_mac3 #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OFFSET_EN(1'b0)) u_mac_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .px_a   (per_img_red),
    .px_b   (per_img_green),
    .px_c   (per_img_blue),
    .coef_a (coef_c.y_r),
    .coef_b (coef_c.y_g),
    .coef_c (coef_c.y_b),
    .out_en (href_sr_q[1]),
    .result (post_img_Y)
  );

  csc_mac3 #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OFFSET_EN(1'b1)) u_mac_cb (
    .clk    (clk),
    .rst_n  (rst_n),
    .px_a   (per_img_red),
    .px_b   (per_img_green),
    .px_c   (per_img_blue),
    .coef_a (coef_c.cb_r),
    .coef_b (coef_c.cb_g),
    .coef_c (coef_c.cb_b),
    .out_en (href_sr_q[1]),
    .result (post_img_Cb)
  );

  csc_mac3 #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OFFSET_EN(1'b1)) u_mac_cr (
    .clk    (clk),
    .rst_n  (rst_n),
    .px_a   (per_img_red),
    .px_b   (per_img_green),
    .px_c   (per_img_blue),
    .coef_a (coef_c.cr_r),
    .coef_b (coef_c.cr_g),
    .coef_c (coef_c.cr_b),
    .out_en (href_sr_q[1]),
    .result (post_img_Cr)
  );

  assign post_img_vsync = vsync_sr_q[2];
  assign post_img_href  = href_sr_q[2];
  assign active_std     = active_std_q;

endmodule

// File: tb/tb_ycbcr_csc_pipe.sv
// Randomised and directed bench for ycbcr_csc_pipe against a pixel-level reference model.
module tb_ycbcr_csc_pipe;

  localparam int unsigned DW = 8;
`ifdef CSC_BT709_EN
  localparam bit BT709_EN = 1'b1;
`else
  localparam bit BT709_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_img_vsync, per_img_href, std_sel;
  logic [DW-1:0] per_img_red, per_img_green, per_img_blue;
  logic          post_img_vsync, post_img_href, active_std;
  logic [DW-1:0] post_img_Y, post_img_Cb, post_img_Cr;

  always #5 clk = ~clk;

  ycbcr_csc_pipe #(.DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_red    (per_img_red),
    .per_img_green  (per_img_green),
    .per_img_blue   (per_img_blue),
    .std_sel        (std_sel),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_Y     (post_img_Y),
    .post_img_Cb    (post_img_Cb),
    .post_img_Cr    (post_img_Cr),
    .active_std     (active_std)
  );

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic [DW-1:0] y;
    logic [DW-1:0] cb;
    logic [DW-1:0] cr;
  } exp_t;

  exp_t q[$];
  exp_t exp_now;
  int   std_m, prev_m, armed_m;
  int   checks, errors, cyc;

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Converts one pixel with the standard's Q8 formulas
  function automatic exp_t ref_px(input logic vs, input logic hs,
                                  input int r, input int g, input int b, input int std);
    exp_t e;
    int   c[9];
    if (std == 0) c = '{76, 150, 29, -43, -84, 128, 128, -107, -20};
    else          c = '{54, 183, 18, -29, -99, 128, 128, -116, -12};
    e.vs = vs;
    e.hs = hs;
    e.y  = '0;
    e.cb = '0;
    e.cr = '0;
    if (hs) begin
      e.y  = DW'(clampi((c[0]*r + c[1]*g + c[2]*b + 128) >>> 8));
      e.cb = DW'(clampi((c[3]*r + c[4]*g + c[5]*b + 32768 + 128) >>> 8));
      e.cr = DW'(clampi((c[6]*r + c[7]*g + c[8]*b + 32768 + 128) >>> 8));
    end
    return e;
  endfunction

  task automatic step(input logic rn, input logic vs, input logic hs,
                      input int r, input int g, input int b, input logic sel);
    logic [DW*3+2:0] got, want;
    exp_t zero;
    zero          = '0;
    rst_n         = rn;
    per_img_vsync = vs;
    per_img_href  = hs;
    per_img_red   = DW'(r);
    per_img_green = DW'(g);
    per_img_blue  = DW'(b);
    std_sel       = sel;
    @(posedge clk);
    if (!rn) begin
      std_m   = 0;
      prev_m  = 0;
      armed_m = 0;
      q       = {zero, zero};
      exp_now = zero;
    end else begin
      q.push_back(ref_px(vs, hs, r, g, b, std_m));
      if (armed_m != 0 && prev_m == 0 && vs && BT709_EN) std_m = int'(sel);
      prev_m  = int'(vs);
      armed_m = 1;
      if (q.size() > 3) void'(q.pop_front());
      exp_now = q[0];
    end
    #1;
    cyc++;
    got  = {post_img_vsync, post_img_href, post_img_Y, post_img_Cb, post_img_Cr, active_std};
    want = {exp_now.vs, exp_now.hs, exp_now.y, exp_now.cb, exp_now.cr, std_m[0]};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step cyc=%0d got{vs,hs,Y,Cb,Cr,std}=%h expected=%h", cyc, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1, 200, 100, 50, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10, 20, 30, 1'b1);
    idle(3);
  endtask

  task automatic test_vectors();
    step(1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 255, 255, 255, 1'b0);
    step(1'b1, 1'b0, 1'b1, 255, 0, 0, 1'b0);
    checks++;
    if (post_img_Y !== 8'd0 || post_img_Cb !== 8'd128 || post_img_Cr !== 8'd128) begin
      errors++;
      $display("FAIL black Y/Cb/Cr=%0d/%0d/%0d expected 0/128/128", post_img_Y, post_img_Cb, post_img_Cr);
    end
    step(1'b1, 1'b0, 1'b1, 0, 0, 255, 1'b0);
    checks++;
    if (post_img_Y !== 8'd254 || post_img_Cb !== 8'd129 || post_img_Cr !== 8'd129) begin
      errors++;
      $display("FAIL white Y/Cb/Cr=%0d/%0d/%0d expected 254/129/129", post_img_Y, post_img_Cb, post_img_Cr);
    end
    idle(1);
    checks++;
    if (post_img_Y !== 8'd76 || post_img_Cb !== 8'd85 || post_img_Cr !== 8'd255) begin
      errors++;
      $display("FAIL red Y/Cb/Cr=%0d/%0d/%0d expected 76/85/255", post_img_Y, post_img_Cb, post_img_Cr);
    end
    idle(1);
    checks++;
    if (post_img_Cb !== 8'd255) begin
      errors++;
      $display("FAIL blue_cb got %0d expected 255", post_img_Cb);
    end
    idle(2);
  endtask

  task automatic test_std_switch();
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(1);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), 1'(i));
    idle(3);
    checks++;
    if (active_std !== 1'b0) begin
      errors++;
      $display("FAIL midframe_std got %0b expected 0", active_std);
    end
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    checks++;
    if (active_std !== BT709_EN) begin
      errors++;
      $display("FAIL vsync_latch got %0b expected %0b", active_std, BT709_EN);
    end
    step(1'b1, 1'b0, 1'b1, 255, 0, 0, 1'b0);
    idle(2);
    checks++;
    if (post_img_Y !== (BT709_EN ? 8'd54 : 8'd76)) begin
      errors++;
      $display("FAIL switched_red_y got %0d expected %0d", post_img_Y, BT709_EN ? 54 : 76);
    end
    // vsync rising together with a pixel: that pixel keeps the old set
    step(1'b1, 1'b1, 1'b1, 255, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 255, 0, 0, 1'b0);
    idle(4);
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b0);
    step(1'b0, 1'b0, 1'b1, 9, 9, 9, 1'b1);
    checks++;
    if ({post_img_vsync, post_img_href, post_img_Y, post_img_Cb, post_img_Cr, active_std} !== '0) begin
      errors++;
      $display("FAIL midline_reset outputs not zero: Y=%0d Cb=%0d Cr=%0d std=%0b",
               post_img_Y, post_img_Cb, post_img_Cr, active_std);
    end
    step(1'b1, 1'b0, 1'b1, 255, 255, 255, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (post_img_href !== 1'b0) begin
      errors++;
      $display("FAIL early_href got %0b expected 0", post_img_href);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (post_img_href !== 1'b1 || post_img_Y !== 8'd254) begin
      errors++;
      $display("FAIL post_reset_latency href=%0b Y=%0d expected 1/254", post_img_href, post_img_Y);
    end
    idle(2);
  endtask

  task automatic test_vsync_at_release();
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    checks++;
    if (active_std !== 1'b0) begin
      errors++;
      $display("FAIL vsync_high_at_release got %0b expected 0", active_std);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    idle(3);
  endtask

  task automatic test_random();
    logic vs, hs;
    vs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) vs = ~vs;
      hs = ($urandom_range(3) != 0);
      step(1'b1, vs, hs, $urandom_range(255), $urandom_range(255), $urandom_range(255),
           1'($urandom_range(1)));
    end
    idle(3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_vectors();
    test_std_switch();
    test_reset_midline();
    test_vsync_at_release();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ycbcr_csc_pipe.md
YCBCR_CSC_PIPE -- requirements
Module: ycbcr_csc_pipe

Interface
REQ-001 Parameter DATA_W, default 8, per-component pixel width, legal range 8..12.
REQ-002 Parameter FRAC_W, default 8, coefficient fraction bits; the coefficient tables are defined for 8 only.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 per_img_vsync  input  1  frame sync in, active high.
REQ-006 per_img_href  input  1  line/pixel valid in, active high.
REQ-007 per_img_red, per_img_green, per_img_blue  input  DATA_W each  unsigned RGB pixel.
REQ-008 std_sel  input  1  requested standard: 0 = BT.601, 1 = BT.709.
REQ-009 post_img_vsync, post_img_href  output  1 each  syncs delayed to match data.
REQ-010 post_img_Y, post_img_Cb, post_img_Cr  output  DATA_W each  unsigned YCbCr pixel.
REQ-011 active_std  output  1  standard currently applied to the pipeline.

Function
REQ-012 Q8 coefficients: BT.601 Y = 76R+150G+29B, Cb = -43R-84G+128B, Cr = 128R-107G-20B.
REQ-013 Q8 coefficients: BT.709 Y = 54R+183G+18B, Cb = -29R-99G+128B, Cr = 128R-116G-12B.
REQ-014 Cb and Cr sums add the offset 2^(DATA_W-1) << FRAC_W; Y has no offset.
REQ-015 Arithmetic is signed at width DATA_W+FRAC_W+2, with no intermediate overflow for any input.
REQ-016 Rounding: add 2^(FRAC_W-1), then arithmetic right shift by FRAC_W.
REQ-017 Saturation: results below 0 give 0; results above 2^DATA_W-1 give 2^DATA_W-1.
REQ-018 Pipeline: stage 1 registers the products; stage 2 registers the offset sums plus rounding; stage 3 registers the shifted and clamped result.
REQ-019 Latency is exactly 3 clk; the pipeline accepts one pixel per cycle with no stall.
REQ-020 post_img_vsync and post_img_href equal the inputs delayed by 3 clk through shift registers.
REQ-021 When post_img_href is 0, post_img_Y, post_img_Cb and post_img_Cr are forced to 0.
REQ-022 std_sel is sampled only on a detected rising edge of per_img_vsync (previous cycle 0, current 1); it is ignored at all other times.
REQ-023 The sampled value is loaded into active_std on that cycle and applies to stage 1 from the next cycle onward.
REQ-024 Toggling std_sel mid-frame has no effect until the next vsync rising edge.
REQ-025 Pixels already in flight complete with the coefficient set captured at their stage-1 cycle, so no pixel mixes standards.
REQ-026 If vsync rises while href is 1, the vsync update takes effect and that cycle's pixel uses the old set.

Reset
REQ-027 While rst_n is 0 at a clk edge, every pipeline, product and sync register clears to 0, active_std clears to 0 (BT.601), and the vsync edge detector clears to 0.
REQ-028 All outputs read 0 during the first cycle after reset release; reset asserted mid-frame discards in-flight pixels without partial output.
REQ-029 A vsync that is already high at reset release does not count as a rising edge.

Configuration
REQ-030 Macro CSC_BT709_EN: when defined, the BT.709 table and the std_sel latching are compiled in.
REQ-031 When CSC_BT709_EN is undefined, std_sel is ignored, active_std is constant 0, and only the BT.601 table exists; all else is unchanged.

Structure
REQ-032 Package csc_pkg holds FRAC_W_DEF, the csc_std_e enum (BT601, BT709), the coef_set_t struct of nine signed coefficients, and the constant tables COEF_BT601 and COEF_BT709.
REQ-033 Sub-module csc_mac3 computes one channel (three products, offset, round, clamp, 3-stage registered) and is instantiated three times, once each for Y, Cb and Cr.

Verification
REQ-034 DATA_W=8, BT.601, RGB=(0,0,0) with href=1 -> 3 clk later Y=0, Cb=128, Cr=128.
REQ-035 DATA_W=8, BT.601, RGB=(255,255,255) -> Y=254, Cb=129, Cr=129.
REQ-036 DATA_W=8, BT.601, RGB=(255,0,0) -> Y=76, Cb=85, Cr=255 (saturated from 256); RGB=(0,0,255) -> Cb=255 (saturated).
REQ-037 Continuous href stream of 16 pixels with std_sel toggled mid-frame -> outputs stay BT.601 and active_std stays 0; after the next vsync rising edge with std_sel=1, active_std=1 and RGB=(255,0,0) gives Y=54.
REQ-038 rst_n pulsed low for 1 cycle mid-line -> next cycle all outputs 0 and active_std=0; the first pixel after release appears exactly 3 clk after its input.
REQ-039 Build without CSC_BT709_EN, std_sel=1 across a vsync rising edge -> active_std=0 and RGB=(255,0,0) gives Y=76.
